// File: rtl/operand_b_pipe.sv
// operand_b_pipe: registered ALU B-operand selector.
// Picks a source slot or the PC-increment constant, applies an immediate
// transform, and holds the result in an output register backed by a one-entry
// skid register so the ALU can stall without losing an accepted operand.
module operand_b_pipe #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 8,
    parameter int SEL_W     = 3,
    parameter int CONST_IDX = 1,
    parameter int CONST_VAL = 4,
    parameter int IMM_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              mode,
    input  logic [N_SRC*DATA_W-1:0] src_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    err_clr,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    logic                live;
    logic [DATA_W-1:0]   skid_data;
    logic [DATA_W-1:0]   picked;
    logic [DATA_W-1:0]   operand;
    logic [IMM_W-1:0]    imm;
    logic                sel_oob;
    logic                accept;
    logic                pop;

    // Handshake decode; in_ready comes from registers only, never from out_ready.
    assign in_ready = live && (state != FULL);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign sel_oob  = (int'(sel) >= N_SRC);

    // Source selection: the constant slot overrides its bus word, out-of-range gives zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        picked = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) picked = src_bus[k*DATA_W +: DATA_W];
        end
        if (sel == SEL_W'(CONST_IDX)) picked = DATA_W'(CONST_VAL);
    end

    // Immediate transform on the low IMM_W bits; the shift drops bits off the top.
    always_comb begin
        imm     = picked[IMM_W-1:0];
        operand = picked;
        case (mode)
            2'b00: operand = picked;
            2'b01: operand = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            2'b10: operand = {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
            2'b11: operand = {{(DATA_W-IMM_W){1'b0}}, imm};
            default: operand = picked;
        endcase
    end

    // Ready qualifier: stays low during reset and rises on the first clock after release.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (!reset) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Output/skid state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data registers are reset too, so a reset mid-transfer leaves no stale operand visible.
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= operand;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (pop && accept) begin
                        out_data <= operand;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (accept) begin
                        skid_data <= operand;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_data <= skid_data;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    // Sticky selector error; a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  sel_err <= 1'b0;
        else if (accept && sel_oob)  sel_err <= 1'b1;
        else if (err_clr)            sel_err <= 1'b0;
    end

endmodule

// File: tb/tb_operand_b_pipe.sv
// Directed and randomised checks for operand_b_pipe with N_SRC=5.
module tb_operand_b_pipe;

    localparam int DW = 32;
    localparam int NS = 5;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SW-1:0]     sel = '0;
    logic [1:0]        mode = '0;
    logic [NS*DW-1:0]  src_bus;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              err_clr = 1'b0;
    logic              sel_err;

    int n_tests = 0;
    int n_fail  = 0;

    operand_b_pipe #(
        .DATA_W(DW), .N_SRC(NS), .SEL_W(SW),
        .CONST_IDX(1), .CONST_VAL(4), .IMM_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .src_bus(src_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_clr(err_clr), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [1:0] m);
        in_valid = v;
        sel      = s;
        mode     = m;
    endtask

    // One clock: inputs were set at a falling edge, outputs are read at the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference operand for a request.
    function automatic logic [31:0] model(input logic [SW-1:0] s, input logic [1:0] m,
                                          input logic [NS*DW-1:0] bus);
        logic [31:0] w;
        logic [15:0] l;
        if (s == 3'd1)      w = 32'd4;
        else if (s < 3'd5)  w = bus[s*32 +: 32];
        else                w = 32'd0;
        l = w[15:0];
        case (m)
            2'b00:   return w;
            2'b01:   return {{16{l[15]}}, l};
            2'b10:   return {{14{l[15]}}, l, 2'b00};
            default: return {16'h0000, l};
        endcase
    endfunction

    logic [31:0] q[$];
    logic        err_m;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        acc;
    logic        pp;

    initial begin
        src_bus = {32'hCAFE0123, 32'h00008001, 32'hDEADBEEF, 32'h11111111, 32'h1234FFFC};
        repeat (2) @(negedge clk);

        // Reset release, then fill to FULL and reset mid-FULL.
        reset = 1'b1;
        step();
        check("rdy_after_init", 32'(in_ready), 32'd1);
        check("ov_after_init", 32'(out_valid), 32'd0);
        drive(1'b1, 3'd2, 2'b00);
        step();
        check("fill_a_data", out_data, 32'hDEADBEEF);
        drive(1'b1, 3'd7, 2'b00);
        step();
        check("full_rdy", 32'(in_ready), 32'd0);
        check("full_err", 32'(sel_err), 32'd1);
        drive(1'b0, 3'd0, 2'b00);
        reset = 1'b0;
        #1;
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", 32'(sel_err), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("rdy_after_rel", 32'(in_ready), 32'd1);
        check("ov_after_rel", 32'(out_valid), 32'd0);

        // Constant slot and plain slot.
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 2'b00);
        step();
        check("const_ov", 32'(out_valid), 32'd1);
        check("const_data", out_data, 32'h00000004);
        drive(1'b1, 3'd2, 2'b00);
        step();
        check("slot2_data", out_data, 32'hDEADBEEF);
        drive(1'b0, 3'd0, 2'b00);
        step();
        check("drain_ov", 32'(out_valid), 32'd0);

        // Transform modes.
        drive(1'b1, 3'd0, 2'b01); step(); check("sext", out_data, 32'hFFFFFFFC);
        drive(1'b1, 3'd0, 2'b10); step(); check("sext_sh2", out_data, 32'hFFFFFFF0);
        drive(1'b1, 3'd0, 2'b11); step(); check("zext", out_data, 32'h0000FFFC);
        drive(1'b1, 3'd0, 2'b00); step(); check("pass", out_data, 32'h1234FFFC);
        drive(1'b1, 3'd3, 2'b01); step(); check("sext_neg", out_data, 32'hFFFF8001);
        drive(1'b1, 3'd4, 2'b10); step(); check("sh2_pos", out_data, 32'h0000048C);
        drive(1'b1, 3'd1, 2'b10); step(); check("const_sh2", out_data, 32'h00000010);
        drive(1'b0, 3'd0, 2'b00); step();

        // Stall: A, B, C back to back with the ALU stalled.
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 2'b00);
        step();
        check("stall_a", out_data, 32'hDEADBEEF);
        check("stall_rdy1", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd4, 2'b00);
        step();
        check("stall_b_hold", out_data, 32'hDEADBEEF);
        check("stall_rdy_full", 32'(in_ready), 32'd0);
        drive(1'b1, 3'd3, 2'b00);
        step();
        check("stall_c_hold", out_data, 32'hDEADBEEF);
        check("stall_c_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("pop_b", out_data, 32'hCAFE0123);
        check("pop_b_rdy", 32'(in_ready), 32'd1);
        step();
        check("pop_c", out_data, 32'h00008001);
        drive(1'b0, 3'd0, 2'b00);
        step();
        check("pop_empty", 32'(out_valid), 32'd0);

        // Sticky selector error.
        drive(1'b1, 3'd7, 2'b00);
        step();
        check("oob_data", out_data, 32'd0);
        check("oob_err", 32'(sel_err), 32'd1);
        drive(1'b0, 3'd0, 2'b00);
        step();
        check("err_sticky", 32'(sel_err), 32'd1);
        err_clr = 1'b1;
        drive(1'b1, 3'd6, 2'b00);
        step();
        check("err_set_wins", 32'(sel_err), 32'd1);
        drive(1'b0, 3'd0, 2'b00);
        step();
        check("err_cleared", 32'(sel_err), 32'd0);
        err_clr = 1'b0;
        drive(1'b0, 3'd7, 2'b00);
        step();
        check("idle_no_err", 32'(sel_err), 32'd0);

        // Random traffic against a reference queue.
        step();
        err_m      = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_ov", 32'(out_valid), 32'(q.size() != 0));
            check("rnd_rdy", 32'(in_ready), 32'(q.size() < 2));
            check("rnd_err", 32'(sel_err), 32'(err_m));
            if (q.size() != 0) check("rnd_data", out_data, q[0]);
            if (prev_stall) check("rnd_stable", out_data, prev_data);
            src_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            out_ready = 1'($urandom_range(0, 1));
            err_clr   = ($urandom_range(0, 15) == 0);
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (acc && (sel >= 3'd5)) err_m = 1'b1;
            else if (err_clr)         err_m = 1'b0;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(model(sel, mode, src_bus));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
